// File: rtl/mem_ctrl_pkg.sv
// Shared widths and encodings for the memory responder (state and RAM port-select kinds).
package mem_ctrl_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic {
    MC_S_BOOT,
    MC_S_RUN
  } mc_state_e;

  typedef enum logic [1:0] {
    MC_REQ_NONE,
    MC_REQ_FETCH,
    MC_REQ_LOAD,
    MC_REQ_STORE
  } mc_req_e;

endpackage

// File: rtl/mem_ctrl_sp_ram.sv
// Single-port word RAM: synchronous read, write-first, no reset on contents.
module sp_ram
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned W     = WORD_WIDTH,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Fetch/load/store responder over one single-port RAM with one-deep deferral per read kind.
// Optional boot loader enabled by defining MEM_CTRL_BOOT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned W     = WORD_WIDTH,
  parameter int unsigned DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pc_en,
  input  logic [W-1:0] pc,
  output logic [W-1:0] read_inst,
  output logic         inst_valid,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  output logic         l_valid,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
`ifdef MEM_CTRL_BOOT_EN
  input  logic         boot_valid,
  input  logic [W-1:0] boot_data,
  input  logic         boot_last,
  output logic         boot_ready,
`endif
  output logic         busy,
  output logic         fault,
  output logic [W-1:0] fault_addr
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef MEM_CTRL_BOOT_EN
  localparam mc_state_e RST_STATE = MC_S_BOOT;
`else
  localparam mc_state_e RST_STATE = MC_S_RUN;
`endif

  mc_state_e     state, state_n;
  logic [AW-1:0] boot_ptr;
  logic          boot_rdy;
  logic          b_valid, b_last;
  logic [W-1:0]  b_data;

`ifdef MEM_CTRL_BOOT_EN
  assign b_valid    = boot_valid;
  assign b_data     = boot_data;
  assign b_last     = boot_last;
  assign boot_ready = boot_rdy;
`else
  assign b_valid = 1'b0;
  assign b_data  = '0;
  assign b_last  = 1'b0;
`endif

  logic          pl_v, pf_v;
  logic [AW-1:0] pl_a, pf_a;
  logic [W-1:0]  inst_hold, l_hold, ram_q;

  logic          pc_bad, l_bad, s_bad;
  logic          run, boot_acc, boot_done;
  logic          new_store, new_load, new_fetch, ld_req, f_req;
  logic          s_err, l_err, f_err;
  logic [W-1:0]  err_addr;
  logic [AW-1:0] ld_idx, f_idx;
  mc_req_e       sel;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;

  assign pc_bad = (pc[1:0] != 2'b00)     || (pc[W-1:AW+2] != '0);
  assign l_bad  = (l_addr[1:0] != 2'b00) || (l_addr[W-1:AW+2] != '0);
  assign s_bad  = (s_addr[1:0] != 2'b00) || (s_addr[W-1:AW+2] != '0);

  // Everything is gated by rst so nothing touches the RAM while reset is held.
  assign run       = rst && (state == MC_S_RUN);
  assign boot_acc  = rst && (state == MC_S_BOOT) && boot_rdy && b_valid;
  assign boot_done = boot_acc && (b_last || (boot_ptr == AW'(DEPTH - 1)));

  assign new_store = run && store_en && !s_bad;
  assign new_load  = run && load_en  && !l_bad  && !pl_v;
  assign new_fetch = run && pc_en    && !pc_bad && !pf_v;
  assign ld_req    = (run && pl_v) || new_load;
  assign f_req     = (run && pf_v) || new_fetch;
  assign ld_idx    = pl_v ? pl_a : l_addr[AW+1:2];
  assign f_idx     = pf_v ? pf_a : pc[AW+1:2];

  assign s_err    = run && store_en && s_bad;
  assign l_err    = run && load_en  && (l_bad  || pl_v);
  assign f_err    = run && pc_en    && (pc_bad || pf_v);
  assign err_addr = s_err ? s_addr : (l_err ? l_addr : pc);

  always_comb begin
    state_n = state;
    if (boot_done) state_n = MC_S_RUN;
  end

  always_comb begin
    sel       = MC_REQ_NONE;
    ram_addr  = '0;
    ram_wdata = s_data;
    if (new_store)   sel = MC_REQ_STORE;
    else if (ld_req) sel = MC_REQ_LOAD;
    else if (f_req)  sel = MC_REQ_FETCH;
    unique case (sel)
      MC_REQ_STORE: ram_addr = s_addr[AW+1:2];
      MC_REQ_LOAD:  ram_addr = ld_idx;
      MC_REQ_FETCH: ram_addr = f_idx;
      default:      ram_addr = '0;
    endcase
    if (boot_acc) begin
      ram_addr  = boot_ptr;
      ram_wdata = b_data;
    end
    ram_en = boot_acc || (sel != MC_REQ_NONE);
    ram_we = boot_acc || (sel == MC_REQ_STORE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RST_STATE;
      boot_ptr   <= '0;
      boot_rdy   <= 1'b0;
      pl_v       <= 1'b0;
      pl_a       <= '0;
      pf_v       <= 1'b0;
      pf_a       <= '0;
      inst_valid <= 1'b0;
      l_valid    <= 1'b0;
      inst_hold  <= '0;
      l_hold     <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      state    <= state_n;
      boot_rdy <= (state_n == MC_S_BOOT);
      if (boot_acc) boot_ptr <= boot_ptr + 1'b1;
      // A losing request is parked; a parked one stays until it wins.
      pl_v <= ld_req && (sel != MC_REQ_LOAD);
      pf_v <= f_req  && (sel != MC_REQ_FETCH);
      if (new_load)  pl_a <= l_addr[AW+1:2];
      if (new_fetch) pf_a <= pc[AW+1:2];
      inst_valid <= (sel == MC_REQ_FETCH);
      l_valid    <= (sel == MC_REQ_LOAD);
      if (inst_valid) inst_hold <= ram_q;
      if (l_valid)    l_hold    <= ram_q;
      if (s_err || l_err || f_err) begin
        fault <= 1'b1;
        if (!fault) fault_addr <= err_addr;
      end
    end
  end

  // RAM output is shared; each read port shows it only during its own strobe.
  assign read_inst = inst_valid ? ram_q : inst_hold;
  assign l_data    = l_valid    ? ram_q : l_hold;
  assign busy      = pl_v || pf_v || (state == MC_S_BOOT);

  sp_ram #(
    .W    (W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

endmodule
